// File: rtl/mutex_sched_pkg.sv
// rtl/mutex_sched_pkg.sv - shared types, defaults and rule-guard helper for mutex_rule_scheduler
package mutex_sched_pkg;

    typedef enum logic [1:0] {
        NS_I = 2'd0,
        NS_T = 2'd1,
        NS_C = 2'd2,
        NS_E = 2'd3
    } node_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } sched_state_t;

    localparam int DEF_NODES     = 3;
    localparam int DEF_STALL_MAX = 15;
    localparam int DEF_CNT_W     = 16;
    localparam int WD_W          = 8;

    // A trying node may only fire once the shared resource is free.
    function automatic logic guard_ok(input logic [1:0] s, input logic x);
        return !((s == NS_T) && !x);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin find-first over N request bits from a start pointer
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int c;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(start) + i;
            if (c >= N) c = c - N;
            if (!valid && req[c[IW-1:0]]) begin
                valid = 1'b1;
                idx   = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mutex_rule_scheduler.sv
// rtl/mutex_rule_scheduler.sv - round-robin rule scheduler with stall watchdog and step mode
// Optional mutual-exclusion checker enabled by MUTEX_SCHED_CHECK_EN.
module mutex_rule_scheduler
    import mutex_sched_pkg::*;
#(
    parameter int NODES     = DEF_NODES,
    parameter int STALL_MAX = DEF_STALL_MAX,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int IW        = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_run,
    input  logic               io_step,
    input  logic               io_clear,
    input  logic [2*NODES-1:0] io_n_state,
    input  logic               io_x,
    output logic [NODES-1:0]   io_en_a,
    output logic [IW-1:0]      io_grant_idx,
    output logic               io_busy,
    output logic               io_deadlock,
    output logic [CNT_W-1:0]   io_fire_count
`ifdef MUTEX_SCHED_CHECK_EN
    ,
    output logic               io_mutex_err
`endif
);

    sched_state_t     state, state_n;
    logic [NODES-1:0] req, en_n;
    logic [IW-1:0]    ptr, ptr_n, gidx_n, pick_idx;
    logic             pick_valid;
    logic [WD_W-1:0]  wd, wd_n, wd_inc;
    logic [CNT_W-1:0] cnt_n;

    always_comb begin
        req = '0;
        for (int i = 0; i < NODES; i++)
            req[i] = guard_ok(io_n_state[2*i +: 2], io_x);
    end

    rr_pick #(.N(NODES), .IW(IW)) u_pick (
        .req   (req),
        .start (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef MUTEX_SCHED_CHECK_EN
    logic err_q, err_n;
    int   n_c;
`endif

    always_comb begin
        state_n = state;
        en_n    = '0;
        ptr_n   = ptr;
        gidx_n  = io_grant_idx;
        wd_inc  = wd + 1'b1;
        wd_n    = wd;
        cnt_n   = io_fire_count;
        case (state)
            ST_IDLE: if (io_run || io_step) state_n = ST_ISSUE;
            ST_ISSUE: begin
                if (pick_valid) begin
                    en_n[pick_idx] = 1'b1;
                    ptr_n   = (pick_idx == IW'(NODES - 1)) ? '0 : pick_idx + 1'b1;
                    gidx_n  = pick_idx;
                    wd_n    = '0;
                    cnt_n   = (io_fire_count == '1) ? io_fire_count : io_fire_count + 1'b1;
                    state_n = ST_WAIT;
                end else begin
                    wd_n = wd_inc;
                    if (wd_inc == WD_W'(STALL_MAX) && !io_clear) state_n = ST_HALT;
                    else state_n = io_run ? ST_ISSUE : ST_IDLE;
                end
            end
            ST_WAIT: state_n = io_run ? ST_ISSUE : ST_IDLE;
            ST_HALT: if (io_clear) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Clear beats a same-cycle grant for the watchdog and counter.
        if (io_clear) begin
            wd_n  = '0;
            cnt_n = '0;
        end
`ifdef MUTEX_SCHED_CHECK_EN
        n_c = 0;
        for (int i = 0; i < NODES; i++)
            if (io_n_state[2*i +: 2] == NS_C) n_c = n_c + 1;
        err_n = io_clear ? 1'b0 : (err_q || (n_c >= 2));
        if (err_n) begin
            state_n = ST_HALT;
            en_n    = '0;
            ptr_n   = ptr;
            gidx_n  = io_grant_idx;
            cnt_n   = io_clear ? '0 : io_fire_count;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            io_en_a       <= '0;
            ptr           <= '0;
            io_grant_idx  <= '0;
            wd            <= '0;
            io_fire_count <= '0;
        end else begin
            state         <= state_n;
            io_en_a       <= en_n;
            ptr           <= ptr_n;
            io_grant_idx  <= gidx_n;
            wd            <= wd_n;
            io_fire_count <= cnt_n;
        end
    end

`ifdef MUTEX_SCHED_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_n;
    end
    assign io_mutex_err = err_q;
`endif

    assign io_busy     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign io_deadlock = (state == ST_HALT);

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// tb/tb_mutex_rule_scheduler.sv - directed self-checking bench for mutex_rule_scheduler
module tb_mutex_rule_scheduler;

    logic        clock;
    logic        reset;
    logic        io_run, io_step, io_clear, io_x;
    logic [5:0]  io_n_state;
    logic [2:0]  io_en_a;
    logic [1:0]  io_grant_idx;
    logic        io_busy, io_deadlock;
    logic [15:0] io_fire_count;
`ifdef MUTEX_SCHED_CHECK_EN
    logic        io_mutex_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] ALL_I = 6'b00_00_00;
    localparam logic [5:0] ALL_T = 6'b01_01_01;
    localparam logic [5:0] TTI   = 6'b00_01_01;

    mutex_rule_scheduler #(.NODES(3), .STALL_MAX(15), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_run        (io_run),
        .io_step       (io_step),
        .io_clear      (io_clear),
        .io_n_state    (io_n_state),
        .io_x          (io_x),
        .io_en_a       (io_en_a),
        .io_grant_idx  (io_grant_idx),
        .io_busy       (io_busy),
        .io_deadlock   (io_deadlock),
        .io_fire_count (io_fire_count)
`ifdef MUTEX_SCHED_CHECK_EN
        ,
        .io_mutex_err  (io_mutex_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [2:0]  en_exp  [8];
    logic [15:0] cnt_exp [8];

    initial begin
        en_exp  = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        cnt_exp = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4};

        reset = 1'b0; io_run = 1'b0; io_step = 1'b0; io_clear = 1'b0;
        io_x = 1'b1; io_n_state = ALL_I;
        tick(); tick();
        check("rst_en", 32'(io_en_a), 32'd0);
        check("rst_gidx", 32'(io_grant_idx), 32'd0);
        check("rst_busy", 32'(io_busy), 32'd0);
        check("rst_dead", 32'(io_deadlock), 32'd0);
        check("rst_cnt", 32'(io_fire_count), 32'd0);

        // Free-run, all idle nodes: grants rotate 0,1,2,0 with a gap cycle each.
        reset = 1'b1; io_run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fr_en_%0d", k), 32'(io_en_a), 32'(en_exp[k]));
            check($sformatf("fr_cnt_%0d", k), 32'(io_fire_count), 32'(cnt_exp[k]));
        end
        check("fr_gidx", 32'(io_grant_idx), 32'd0);

        // Drop run during WAIT: pair completes, back to IDLE.
        io_run = 1'b0;
        tick();
        check("stop_busy", 32'(io_busy), 32'd0);
        check("stop_en", 32'(io_en_a), 32'd0);

        // Single step from pointer 1, second step during WAIT ignored.
        io_step = 1'b1;
        tick();
        io_step = 1'b0;
        check("step_busy", 32'(io_busy), 32'd1);
        check("step_en0", 32'(io_en_a), 32'd0);
        tick();
        check("step_en1", 32'(io_en_a), 32'b010);
        check("step_cnt", 32'(io_fire_count), 32'd5);
        io_step = 1'b1;
        tick();
        io_step = 1'b0;
        check("stepw_en", 32'(io_en_a), 32'd0);
        check("stepw_busy", 32'(io_busy), 32'd0);
        tick();
        check("stepw_idle", 32'(io_busy), 32'd0);
        check("stepw_en2", 32'(io_en_a), 32'd0);
        check("stepw_cnt", 32'(io_fire_count), 32'd5);

        // Another step grants node 2, then reset hits while the enable is high.
        io_step = 1'b1;
        tick();
        io_step = 1'b0;
        tick();
        check("pre_rst_en", 32'(io_en_a), 32'b100);
        check("pre_rst_gidx", 32'(io_grant_idx), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("async_en", 32'(io_en_a), 32'd0);
        check("async_busy", 32'(io_busy), 32'd0);
        check("async_cnt", 32'(io_fire_count), 32'd0);
        check("async_gidx", 32'(io_grant_idx), 32'd0);
        tick();
        reset = 1'b1;

        // {T,T,I} with x=0 from pointer 0: node 2 wins, pointer wraps to 0.
        io_run = 1'b1; io_x = 1'b0; io_n_state = TTI;
        tick();
        check("tti_issue", 32'(io_en_a), 32'd0);
        tick();
        check("tti_en", 32'(io_en_a), 32'b100);
        check("tti_gidx", 32'(io_grant_idx), 32'd2);
        io_x = 1'b1; io_n_state = ALL_I;
        tick();
        check("wrap_gap", 32'(io_en_a), 32'd0);
        tick();
        check("wrap_en", 32'(io_en_a), 32'b001);
        check("wrap_cnt", 32'(io_fire_count), 32'd2);

        // All trying with x=0: 15 empty decisions then HALT.
        io_x = 1'b0; io_n_state = ALL_T;
        tick();
        for (int k = 1; k < 15; k++) begin
            tick();
            check($sformatf("stall_en_%0d", k), 32'(io_en_a), 32'd0);
            check($sformatf("stall_dead_%0d", k), 32'(io_deadlock), 32'd0);
        end
        tick();
        check("halt_dead", 32'(io_deadlock), 32'd1);
        check("halt_busy", 32'(io_busy), 32'd0);
        check("halt_en", 32'(io_en_a), 32'd0);
        tick();
        check("halt_hold", 32'(io_deadlock), 32'd1);
        check("halt_cnt", 32'(io_fire_count), 32'd2);
        io_clear = 1'b1; io_run = 1'b0;
        tick();
        io_clear = 1'b0;
        check("clr_dead", 32'(io_deadlock), 32'd0);
        check("clr_busy", 32'(io_busy), 32'd0);
        check("clr_cnt", 32'(io_fire_count), 32'd0);

        // Clear coinciding with a grant: counter stays 0, grant still issued.
        io_x = 1'b1; io_n_state = ALL_I; io_run = 1'b1;
        tick();
        io_clear = 1'b1;
        tick();
        io_clear = 1'b0; io_run = 1'b0;
        check("clrw_en", 32'(io_en_a), 32'b010);
        check("clrw_cnt", 32'(io_fire_count), 32'd0);
        check("clrw_busy", 32'(io_busy), 32'd1);
        tick();
        check("clrw_idle", 32'(io_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mutex_rule_scheduler.md
Name: mutex_rule_scheduler

Overview:
- Rule scheduler for the Murphi-derived mutual-exclusion `system`: drives its `io_en_a` one-hot rule-enable vector.
- Samples node states and the shared flag `x`, evaluates rule guards, and round-robins among nodes with an enabled rule.
- Issues at most one rule per two cycles so the state update is visible before the next decision.
- Detects global deadlock with a stall watchdog; supports free-run and single-step modes.

Parameters:
- NODES, 3, number of nodes; width of `io_en_a`.
- STALL_MAX, 15, consecutive no-winner decisions before halting (1..255).
- CNT_W, 16, width of the fired-rule counter.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_run  in  1  1 = free-run scheduling.
- io_step  in  1  one-cycle pulse: one decision when io_run=0.
- io_clear  in  1  synchronous: leave HALT, zero watchdog and counter.
- io_n_state  in  2*NODES  node i state at bits [2i+1:2i]: 0=I, 1=T, 2=C, 3=E.
- io_x  in  1  shared flag from system (1 = resource free).
- io_en_a  out  NODES  registered one-hot rule enable to system; 0 = no rule.
- io_grant_idx  out  clog2(NODES)  index of the last granted node.
- io_busy  out  1  high in ISSUE or WAIT.
- io_deadlock  out  1  high in HALT.
- io_fire_count  out  CNT_W  rules fired since reset/clear; saturating.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, io_en_a=0, io_grant_idx=0, RR pointer=0, watchdog=0, io_fire_count=0, io_deadlock=0, io_busy=0.
- Guard per node: enabled unless state=T and io_x=0. States I, C, E are always enabled.
- FSM states:
  - IDLE: go to ISSUE if io_run=1, or if io_step=1 (step latched).
  - ISSUE: the decision cycle, evaluated combinationally from current inputs.
    - Winner exists: search starts at the RR pointer and wraps modulo NODES; first enabled node wins.
    - On a winner: io_en_a <= one-hot(winner) at the next edge; pointer <= (winner+1) mod NODES; io_grant_idx <= winner; watchdog <= 0; io_fire_count +1 (saturates at all-ones); go to WAIT.
    - No winner: io_en_a <= 0; watchdog +1. If the new value equals STALL_MAX, go to HALT. Otherwise stay in ISSUE if io_run=1, else go to IDLE.
  - WAIT: io_en_a is high for exactly this one cycle and the system updates at the edge ending it. io_en_a <= 0. Go to ISSUE if io_run=1, else IDLE.
  - HALT: io_deadlock=1, io_en_a=0. Only io_clear (or reset) exits, to IDLE.
- Latency: decision edge to io_en_a high is 1 cycle. Free-run peak rate is 1 rule per 2 cycles.
- io_step pulses arriving in ISSUE or WAIT are ignored, not queued.
- io_run dropping mid-operation: the current ISSUE/WAIT pair completes, then the FSM returns to IDLE. A grant is never truncated.
- io_clear while not in HALT: zeroes watchdog and counter only; FSM state is unchanged.
- io_clear and a winner in the same cycle: clear takes priority for the counter, which becomes 0, not 1.
- Never more than one bit of io_en_a set. io_en_a is never high in two consecutive cycles.
- Pointer wrap: NODES-1 -> 0.

Optional Feature:
- Macro: MUTEX_SCHED_CHECK_EN.
- Defined:
  - Adds output io_mutex_err (1 bit), a sticky flag set when two or more nodes are in state C in the same cycle. Cleared by reset or io_clear.
  - While set, the FSM forces HALT.
- Undefined:
  - Port and logic absent; no effect on scheduling.

Decomposition:
- Package `mutex_sched_pkg`:
  - node-state enum (I, T, C, E);
  - FSM state enum (IDLE, ISSUE, WAIT, HALT);
  - guard function;
  - default constants.
- Sub-module `rr_pick`:
  - combinational round-robin find-first over NODES request bits with a start pointer;
  - outputs valid and index.

Test Plan:
- All nodes I, x=1, io_run=1 -> io_en_a sequence 001, 0, 010, 0, 100, 0, 001; io_fire_count=4 after 8 cycles.
- States {T,T,I}, x=0 -> node 2 granted (100) even with pointer=0; pointer becomes 0.
- All T, x=0, io_run=1, STALL_MAX=15 -> io_deadlock=1 after 15 ISSUE cycles, io_en_a stays 0; io_clear -> IDLE, count 0.
- io_run=0, single io_step with all I -> exactly one io_en_a=001 pulse, then IDLE. A second step pulse during WAIT has no effect.
- Assert reset low while io_en_a=010 -> io_en_a=0 and FSM=IDLE immediately; pointer=0 after release.
- MUTEX_SCHED_CHECK_EN defined, states {C,C,I} -> io_mutex_err=1 next cycle, FSM=HALT, io_en_a=0.
